an_sec_decode_ctrl: RTL and testbench

- Sequencing controller for single-error correction (SEC) of 43-bit product (AN) codewords, A = 17619, carrying 28-bit payloads.
- Accepts a received codeword over a valid/ready handshake and reduces it serially to a 15-bit remainder r = cw mod A.
- Presents r to the external combinational remainder-to-location LUT and applies the returned signed error location to correct the word.
- Sits between the memory read path and the payload extractor. Keeps saturating statistics counters.

---
 rtl/an_sec_decode_ctrl_if.sv | 34 +++
 rtl/an_sec_decode_ctrl.sv | 135 +++++++++++++
 tb/tb_an_sec_decode_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/an_sec_decode_ctrl_if.sv
// rtl/an_sec_decode_ctrl_if.sv - handshake, LUT and statistics bundle for the AN-code SEC decode controller
interface an_sec_decode_ctrl_if #(
  parameter int unsigned CW_W  = 43,
  parameter int unsigned R_W   = 15,
  parameter int unsigned L_W   = 7,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [CW_W-1:0]  in_cw;
  logic [R_W-1:0]   lut_r;
  logic [L_W-1:0]   lut_l;
  logic             out_valid;
  logic             out_ready;
  logic [CW_W-1:0]  out_cw;
  logic             out_corr;
  logic             out_uncorr;
  logic [L_W-1:0]   out_loc;
  logic [CNT_W-1:0] cnt_corr;
  logic [CNT_W-1:0] cnt_uncorr;
  logic             clr_cnt;

  modport slave (
    input  in_valid, in_cw, lut_l, out_ready, clr_cnt,
    output in_ready, lut_r, out_valid, out_cw, out_corr, out_uncorr, out_loc,
           cnt_corr, cnt_uncorr
  );

  modport master (
    output in_valid, in_cw, lut_l, out_ready, clr_cnt,
    input  in_ready, lut_r, out_valid, out_cw, out_corr, out_uncorr, out_loc,
           cnt_corr, cnt_uncorr
  );
endinterface

// File: rtl/an_sec_decode_ctrl.sv
// rtl/an_sec_decode_ctrl.sv - serial mod-A reduction and single-error correction sequencer for AN codewords
module an_sec_decode_ctrl #(
  parameter int unsigned CW_W  = 43,
  parameter int unsigned A     = 17619,
  parameter int unsigned R_W   = 15,
  parameter int unsigned L_W   = 7,
  parameter int unsigned CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  an_sec_decode_ctrl_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(CW_W);
  localparam logic [R_W:0]   A_EXT   = (R_W+1)'(A);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, REDUCE, LOOKUP, CORRECT, OUT} state_t;

  state_t             state_q;
  logic [CW_W-1:0]    cw_q;
  logic [R_W-1:0]     r_q;
  logic [IDX_W-1:0]   idx_q;
  logic [L_W-1:0]     l_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [CW_W-1:0]    out_cw_q;
  logic               out_corr_q;
  logic               out_uncorr_q;
  logic [L_W-1:0]     out_loc_q;
  logic [CNT_W-1:0]   cnt_corr_q;
  logic [CNT_W-1:0]   cnt_uncorr_q;

  logic [R_W:0]       r_sum_d;
  logic [R_W:0]       r_d;
  logic [L_W-1:0]     mag_d;
  logic [CW_W-1:0]    pow_d;
  logic [CW_W-1:0]    fix_cw_d;
  logic               inc_corr_d;
  logic               inc_uncorr_d;

  always_comb begin
    // r < A is invariant, so 2r+bit < 2A and a single subtract restores it
    r_sum_d      = {r_q, cw_q[idx_q]};
    r_d          = (r_sum_d >= A_EXT) ? (r_sum_d - A_EXT) : r_sum_d;
    mag_d        = l_q[L_W-1] ? (~l_q + 1'b1) : l_q;
    pow_d        = {{(CW_W-1){1'b0}}, 1'b1} << (mag_d - 1'b1);
    fix_cw_d     = l_q[L_W-1] ? (cw_q + pow_d) : (cw_q - pow_d);
    inc_corr_d   = (state_q == CORRECT) && (r_q != '0) && (l_q != '0);
    inc_uncorr_d = (state_q == CORRECT) && (r_q != '0) && (l_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cw_q         <= '0;
      r_q          <= '0;
      idx_q        <= '0;
      l_q          <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_cw_q     <= '0;
      out_corr_q   <= 1'b0;
      out_uncorr_q <= 1'b0;
      out_loc_q    <= '0;
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            cw_q       <= bus.in_cw;
            r_q        <= '0;
            idx_q      <= IDX_W'(CW_W - 1);
            in_ready_q <= 1'b0;
            state_q    <= REDUCE;
          end
        end
        REDUCE: begin
          r_q   <= r_d[R_W-1:0];
          idx_q <= idx_q - 1'b1;
          if (idx_q == '0) state_q <= LOOKUP;
        end
        LOOKUP: begin
          l_q     <= bus.lut_l;
          state_q <= CORRECT;
        end
        CORRECT: begin
          out_valid_q <= 1'b1;
          state_q     <= OUT;
          if (r_q == '0) begin
            out_cw_q     <= cw_q;
            out_corr_q   <= 1'b0;
            out_uncorr_q <= 1'b0;
            out_loc_q    <= '0;
          end else begin
            out_cw_q     <= (l_q != '0) ? fix_cw_d : cw_q;
            out_corr_q   <= (l_q != '0);
            out_uncorr_q <= (l_q == '0);
            out_loc_q    <= l_q;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
      endcase

      // clear wins over a same-cycle increment
      if (bus.clr_cnt) begin
        cnt_corr_q   <= '0;
        cnt_uncorr_q <= '0;
      end else begin
        if (inc_corr_d && (cnt_corr_q != CNT_MAX)) cnt_corr_q <= cnt_corr_q + 1'b1;
        if (inc_uncorr_d && (cnt_uncorr_q != CNT_MAX)) cnt_uncorr_q <= cnt_uncorr_q + 1'b1;
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.lut_r      = r_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_cw     = out_cw_q;
  assign bus.out_corr   = out_corr_q;
  assign bus.out_uncorr = out_uncorr_q;
  assign bus.out_loc    = out_loc_q;
  assign bus.cnt_corr   = cnt_corr_q;
  assign bus.cnt_uncorr = cnt_uncorr_q;
endmodule

// File: tb/tb_an_sec_decode_ctrl.sv
// tb/tb_an_sec_decode_ctrl.sv - directed bench for an_sec_decode_ctrl, plus a narrow-counter twin for saturation
module tb_an_sec_decode_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  an_sec_decode_ctrl_if #(.CNT_W(16)) bus ();
  an_sec_decode_ctrl_if #(.CNT_W(3))  bus_s ();

  an_sec_decode_ctrl #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  an_sec_decode_ctrl #(.CNT_W(3))  dut_s (.clk(clk), .rst(rst), .bus(bus_s.slave));

  function automatic logic [6:0] lut(input logic [14:0] r);
    case (r)
      15'd1:    return 7'd1;
      15'd2470: return 7'h70;
      default:  return 7'd0;
    endcase
  endfunction

  always_comb bus.lut_l   = lut(bus.lut_r);
  always_comb bus_s.lut_l = lut(bus_s.lut_r);
  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.in_cw     = bus.in_cw;
  assign bus_s.out_ready = bus.out_ready;
  assign bus_s.clr_cnt   = bus.clr_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_word(input logic [42:0] cw, input int clr_at,
                          output int lat, output logic [14:0] r_seen);
    lat    = -1;
    r_seen = '1;
    for (int k = 0; k < 100 && !bus.in_ready; k++) tick();
    bus.in_valid = 1'b1;
    bus.in_cw    = cw;
    tick();
    bus.in_valid = 1'b0;
    bus.in_cw    = ~cw;
    for (int k = 1; k <= 100; k++) begin
      bus.clr_cnt = (k == clr_at);
      tick();
      if (k == 43) r_seen = bus.lut_r;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    bus.clr_cnt = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [14:0] rs;
    logic        seen;

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_cw     = '0;
    bus.out_ready = 1'b1;
    bus.clr_cnt   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_cw", bus.out_cw, 0);
    chk("rst_flags", {bus.out_corr, bus.out_uncorr}, 0);
    chk("rst_out_loc", bus.out_loc, 0);
    chk("rst_cnts", {bus.cnt_corr, bus.cnt_uncorr}, 0);
    chk("rst_lut_r", bus.lut_r, 0);

    // clean word 5*A
    run_word(43'd88095, 0, lat, rs);
    chk("clean_lat", lat, 45);
    chk("clean_lut_r", rs, 0);
    chk("clean_cw", bus.out_cw, 88095);
    chk("clean_flags", {bus.out_corr, bus.out_uncorr}, 0);
    chk("clean_loc", bus.out_loc, 0);
    chk("clean_cnts", {bus.cnt_corr, bus.cnt_uncorr}, 0);
    tick();
    chk("clean_ret_ready", bus.in_ready, 1);
    chk("clean_ret_valid", bus.out_valid, 0);

    // +1 error at bit 0
    run_word(43'd88096, 0, lat, rs);
    chk("pos_lat", lat, 45);
    chk("pos_lut_r", rs, 1);
    chk("pos_cw", bus.out_cw, 88095);
    chk("pos_corr", bus.out_corr, 1);
    chk("pos_loc", bus.out_loc, 1);
    chk("pos_cnt", bus.cnt_corr, 1);
    tick();

    // -2^15 error
    run_word(43'd55327, 0, lat, rs);
    chk("neg_lut_r", rs, 2470);
    chk("neg_cw", bus.out_cw, 88095);
    chk("neg_loc", bus.out_loc, 7'h70);
    chk("neg_corr", bus.out_corr, 1);
    chk("neg_cnt", bus.cnt_corr, 2);
    tick();

    // double error held under backpressure
    bus.out_ready = 1'b0;
    run_word(43'd88098, 0, lat, rs);
    chk("unc_lat", lat, 45);
    chk("unc_lut_r", rs, 3);
    chk("unc_cw", bus.out_cw, 88098);
    chk("unc_flags", {bus.out_corr, bus.out_uncorr}, 2'b01);
    chk("unc_loc", bus.out_loc, 0);
    chk("unc_cnt", bus.cnt_uncorr, 1);
    bus.in_valid = 1'b1;
    bus.in_cw    = 43'd88095;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {bus.out_valid, bus.in_ready, bus.out_uncorr, bus.out_cw},
          {1'b1, 1'b0, 1'b1, 43'd88098});
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release", {bus.in_ready, bus.out_valid}, 2'b10);
    run_word(43'd88095, 0, lat, rs);
    chk("b2b_lat", lat, 45);
    chk("b2b_cw", bus.out_cw, 88095);
    chk("b2b_flags", {bus.out_corr, bus.out_uncorr}, 0);
    chk("b2b_cnts", {bus.cnt_corr, bus.cnt_uncorr}, {16'd2, 16'd1});
    tick();

    // reset 20 edges after accept
    bus.in_valid = 1'b1;
    bus.in_cw    = 43'd88096;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_idle", {bus.in_ready, bus.out_valid}, 2'b10);
    chk("mrst_cnts", {bus.cnt_corr, bus.cnt_uncorr}, 0);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    chk("mrst_no_out", seen, 0);

    // saturation on the 3-bit-counter twin
    for (int i = 1; i <= 9; i++) begin
      run_word(43'd88096, 0, lat, rs);
      chk("sat_main_cnt", bus.cnt_corr, i);
      chk("sat_twin_cnt", bus_s.cnt_corr, (i > 7) ? 7 : i);
      tick();
    end
    chk("sat_twin_out", {bus_s.out_corr, bus_s.out_cw}, {1'b1, 43'd88095});

    // clear in the same cycle as an increment
    run_word(43'd88096, 45, lat, rs);
    chk("clr_lat", lat, 45);
    chk("clr_corr_flag", bus.out_corr, 1);
    chk("clr_main_cnt", bus.cnt_corr, 0);
    chk("clr_twin_cnt", bus_s.cnt_corr, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
